// File: rtl/uart_host_pkg.sv
// uart_host_pkg: shared definitions for the UART command host.
// Holds frame opcodes, command-type encodings, the FSM state type and
// per-command frame/response lengths.
package uart_host_pkg;

  // Opcode byte that leads each frame
  localparam logic [7:0] RF_WR   = 8'hAA;
  localparam logic [7:0] RF_RD   = 8'hBB;
  localparam logic [7:0] ALU_OP  = 8'hCC;
  localparam logic [7:0] ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CmdRfWr   = 2'b00,
    CmdRfRd   = 2'b01,
    CmdAluOp  = 2'b10,
    CmdAluNop = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitRsp,
    StDone
  } state_e;

  // Bytes on the wire per command type
  localparam logic [2:0] FRAME_LEN_RF_WR   = 3'd3;
  localparam logic [2:0] FRAME_LEN_RF_RD   = 3'd2;
  localparam logic [2:0] FRAME_LEN_ALU_OP  = 3'd4;
  localparam logic [2:0] FRAME_LEN_ALU_NOP = 3'd2;

  // Response bytes expected per command type
  localparam logic [2:0] RSP_LEN_RF_WR   = 3'd0;
  localparam logic [2:0] RSP_LEN_RF_RD   = 3'd1;
  localparam logic [2:0] RSP_LEN_ALU_OP  = 3'd2;
  localparam logic [2:0] RSP_LEN_ALU_NOP = 3'd2;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    unique case (t)
      CmdRfWr:  return FRAME_LEN_RF_WR;
      CmdRfRd:  return FRAME_LEN_RF_RD;
      CmdAluOp: return FRAME_LEN_ALU_OP;
      default:  return FRAME_LEN_ALU_NOP;
    endcase
  endfunction

  function automatic logic [2:0] rsp_len(input cmd_type_e t);
    unique case (t)
      CmdRfWr:  return RSP_LEN_RF_WR;
      CmdRfRd:  return RSP_LEN_RF_RD;
      CmdAluOp: return RSP_LEN_ALU_OP;
      default:  return RSP_LEN_ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_timeout.sv
// uart_host_timeout: loadable response-timeout counter.
// Ports:
//   CLK, RST  - clock, asynchronous active-low reset
//   clear     - restart the count; the current cycle counts as zero
//   enable    - advance the count by one this cycle
//   limit     - terminal count; zero means never expire
//   expired   - high in the cycle the count equals a non-zero limit
module uart_host_timeout #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_eff;

  always_comb begin
    // A clear in this cycle makes this cycle the zero point, so the count
    // seen next cycle is already one.
    cnt_eff = clear ? '0 : cnt_q;
    cnt_d   = cnt_eff + TIMEOUT_W'(enable);
    expired = (limit != '0) && (cnt_eff == limit);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: host-side command initiator for the UART register/ALU protocol.
// Accepts one command, serialises its frame onto a byte-wide TX handshake, then
// gathers the response bytes from RX and reports completion or timeout.
// Ports:
//   CLK, RST                      - clock, asynchronous active-low reset
//   CMD_VLD/CMD_RDY               - command handshake
//   CMD_TYPE/ADDR/DATA/OPB/FUN    - command fields, sampled at acceptance
//   TIMEOUT_CYC                   - response timeout in cycles, 0 disables
//   TX_DATA/TX_VLD/TX_RDY         - frame byte stream out
//   RX_DATA/RX_VLD                - received byte strobe in
//   RSP_DATA/RSP_VLD/RSP_TIMEOUT  - response value and completion pulses
module uart_cmd_host
  import uart_host_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RF_ADDR    = 4,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CMD_VLD,
  output logic                    CMD_RDY,
  input  logic [1:0]              CMD_TYPE,
  input  logic [RF_ADDR-1:0]      CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_DATA,
  input  logic [DATA_WIDTH-1:0]   CMD_OPB,
  input  logic [3:0]              CMD_FUN,
  input  logic [TIMEOUT_W-1:0]    TIMEOUT_CYC,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VLD,
  input  logic                    TX_RDY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VLD,
  output logic [2*DATA_WIDTH-1:0] RSP_DATA,
  output logic                    RSP_VLD,
  output logic                    RSP_TIMEOUT
);

  state_e                  state_q, state_d;
  cmd_type_e               type_q, type_d;
  logic [RF_ADDR-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   opb_q, opb_d;
  logic [3:0]              fun_q, fun_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [1:0]              rx_cnt_q, rx_cnt_d;
  logic [2*DATA_WIDTH-1:0] rsp_q, rsp_d;

  logic [DATA_WIDTH-1:0]   frame_byte;
  logic                    last_byte, last_rx, expired;
  logic                    tmo_clear, tmo_enable;

  // Frame byte selected by position within the latched command
  always_comb begin
    frame_byte = '0;
    unique case (type_q)
      CmdRfWr: begin
        unique case (byte_cnt_q)
          2'd0:    frame_byte = DATA_WIDTH'(RF_WR);
          2'd1:    frame_byte = DATA_WIDTH'(addr_q);
          default: frame_byte = data_q;
        endcase
      end
      CmdRfRd: begin
        frame_byte = (byte_cnt_q == 2'd0) ? DATA_WIDTH'(RF_RD) : DATA_WIDTH'(addr_q);
      end
      CmdAluOp: begin
        unique case (byte_cnt_q)
          2'd0:    frame_byte = DATA_WIDTH'(ALU_OP);
          2'd1:    frame_byte = data_q;
          2'd2:    frame_byte = opb_q;
          default: frame_byte = DATA_WIDTH'(fun_q);
        endcase
      end
      default: begin
        frame_byte = (byte_cnt_q == 2'd0) ? DATA_WIDTH'(ALU_NOP) : DATA_WIDTH'(fun_q);
      end
    endcase
  end

  assign last_byte = ({1'b0, byte_cnt_q} == frame_len(type_q) - 3'd1);
  assign last_rx   = ({1'b0, rx_cnt_q} == rsp_len(type_q) - 3'd1);

  // Counter restarts on every state other than WAIT_RSP and on each received byte
  assign tmo_clear  = (state_q != StWaitRsp) || RX_VLD;
  assign tmo_enable = (state_q == StWaitRsp);

  uart_host_timeout #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .limit  (TIMEOUT_CYC),
    .expired(expired)
  );

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    data_d     = data_q;
    opb_d      = opb_q;
    fun_d      = fun_q;
    byte_cnt_d = byte_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rsp_d      = rsp_q;

    unique case (state_q)
      StIdle: begin
        if (CMD_VLD) begin
          type_d     = cmd_type_e'(CMD_TYPE);
          addr_d     = CMD_ADDR;
          data_d     = CMD_DATA;
          opb_d      = CMD_OPB;
          fun_d      = CMD_FUN;
          byte_cnt_d = 2'd0;
          rx_cnt_d   = 2'd0;
          rsp_d      = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (TX_RDY) begin
          if (last_byte) begin
            byte_cnt_d = 2'd0;
            state_d    = (rsp_len(type_q) == 3'd0) ? StDone : StWaitRsp;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      StWaitRsp: begin
        if (RX_VLD) begin
          if (rx_cnt_q == 2'd0) begin
            rsp_d[DATA_WIDTH-1:0] = RX_DATA;
          end else begin
            rsp_d[2*DATA_WIDTH-1:DATA_WIDTH] = RX_DATA;
          end
          rx_cnt_d = rx_cnt_q + 2'd1;
          if (last_rx) begin
            state_d = StDone;
          end
        end else if (expired) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    CMD_RDY     = (state_q == StIdle);
    TX_VLD      = (state_q == StSend);
    TX_DATA     = TX_VLD ? frame_byte : '0;
    RSP_DATA    = rsp_q;
    RSP_VLD     = (state_q == StDone);
    // A byte arriving on the terminal-count cycle takes priority
    RSP_TIMEOUT = (state_q == StWaitRsp) && !RX_VLD && expired;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      type_q     <= CmdRfWr;
      addr_q     <= '0;
      data_q     <= '0;
      opb_q      <= '0;
      fun_q      <= '0;
      byte_cnt_q <= '0;
      rx_cnt_q   <= '0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      opb_q      <= opb_d;
      fun_q      <= fun_d;
      byte_cnt_q <= byte_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rsp_q      <= rsp_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Self-checking bench for uart_cmd_host: directed scenarios followed by
// randomized commands, all checked against a transaction-level model.
module tb_uart_cmd_host;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VLD;
  logic        CMD_RDY;
  logic [1:0]  CMD_TYPE;
  logic [3:0]  CMD_ADDR;
  logic [7:0]  CMD_DATA;
  logic [7:0]  CMD_OPB;
  logic [3:0]  CMD_FUN;
  logic [15:0] TIMEOUT_CYC;
  logic [7:0]  TX_DATA;
  logic        TX_VLD;
  logic        TX_RDY;
  logic [7:0]  RX_DATA;
  logic        RX_VLD;
  logic [15:0] RSP_DATA;
  logic        RSP_VLD;
  logic        RSP_TIMEOUT;

  always #5 CLK = ~CLK;

  uart_cmd_host #(
    .DATA_WIDTH(8),
    .RF_ADDR   (4),
    .TIMEOUT_W (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_VLD    (CMD_VLD),
    .CMD_RDY    (CMD_RDY),
    .CMD_TYPE   (CMD_TYPE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_DATA   (CMD_DATA),
    .CMD_OPB    (CMD_OPB),
    .CMD_FUN    (CMD_FUN),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_RDY     (TX_RDY),
    .RX_DATA    (RX_DATA),
    .RX_VLD     (RX_VLD),
    .RSP_DATA   (RSP_DATA),
    .RSP_VLD    (RSP_VLD),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  int checks = 0;
  int errors = 0;

  // Current command plan
  logic [1:0]  p_type;
  logic [3:0]  p_addr;
  logic [7:0]  p_a, p_b;
  logic [3:0]  p_fun;
  logic [15:0] p_tmo;
  int          p_txmode;   // 0: always ready, 1: toggle 1/0, 2: random
  bit          p_stray;    // stray RX strobes while the frame is going out
  int          p_nrx;      // response bytes the responder actually sends
  logic [7:0]  p_rx[2];
  int          p_rx_at[2]; // wait-phase cycle index of each response byte
  logic [15:0] last_rsp = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_rsp_len(input logic [1:0] t);
    return (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2;
  endfunction

  // Drives one command through frame, response and return to idle.
  // Entered and left just after a rising edge.
  task automatic run_cmd();
    logic [7:0]  frame[$];
    logic [15:0] exp_rsp;
    int          idx, rlen, k, last_evt;
    bit          done, tmo_hit, exp_to;

    case (p_type)
      2'b00:   frame = '{8'hAA, {4'h0, p_addr}, p_a};
      2'b01:   frame = '{8'hBB, {4'h0, p_addr}};
      2'b10:   frame = '{8'hCC, p_a, p_b, {4'h0, p_fun}};
      default: frame = '{8'hDD, {4'h0, p_fun}};
    endcase
    rlen = exp_rsp_len(p_type);

    CMD_VLD     = 1'b1;
    CMD_TYPE    = p_type;
    CMD_ADDR    = p_addr;
    CMD_DATA    = p_a;
    CMD_OPB     = p_b;
    CMD_FUN     = p_fun;
    TIMEOUT_CYC = p_tmo;
    @(negedge CLK);
    check("cmd_rdy_idle", CMD_RDY, 1);
    @(posedge CLK); #1;
    // Fields must have been captured; scramble them
    CMD_VLD  = 1'b0;
    CMD_TYPE = 2'($urandom);
    CMD_ADDR = 4'($urandom);
    CMD_DATA = 8'($urandom);
    CMD_OPB  = 8'($urandom);
    CMD_FUN  = 4'($urandom);

    idx = 0;
    for (int c = 0; c < 64 && idx < frame.size(); c++) begin
      TX_RDY  = (p_txmode == 0) ? 1'b1 : (p_txmode == 1) ? (c % 2 == 0) : 1'($urandom);
      RX_VLD  = p_stray ? 1'($urandom) : 1'b0;
      RX_DATA = 8'hFF;
      @(negedge CLK);
      check("tx_vld", TX_VLD, 1);
      check("cmd_rdy_busy", CMD_RDY, 0);
      check("tx_data", TX_DATA, frame[idx]);
      if (TX_RDY) idx++;
      @(posedge CLK); #1;
    end
    check("frame_complete", idx, frame.size());
    TX_RDY = 1'b0;
    RX_VLD = 1'b0;

    exp_rsp = 16'h0;
    if (rlen == 0) begin
      @(negedge CLK);
      check("wr_rsp_vld", RSP_VLD, 1);
      check("wr_tx_idle", TX_VLD, 0);
      check("wr_rsp_data", RSP_DATA, 0);
      @(posedge CLK); #1;
    end else begin
      k = 0; last_evt = 0; done = 0; tmo_hit = 0;
      for (int c = 0; c < 400 && !done && !tmo_hit; c++) begin
        RX_VLD  = (k < p_nrx) && (p_rx_at[k] == c);
        RX_DATA = RX_VLD ? p_rx[k] : 8'($urandom);
        @(negedge CLK);
        check("wait_tx_idle", TX_VLD, 0);
        check("wait_rsp_vld", RSP_VLD, 0);
        if (RX_VLD) begin
          check("rx_beats_timeout", RSP_TIMEOUT, 0);
          exp_rsp[8*k +: 8] = p_rx[k];
          k++;
          last_evt = c;
          if (k == rlen) done = 1;
        end else begin
          exp_to = (p_tmo != 0) && (c - last_evt == int'(p_tmo));
          check("rsp_timeout", RSP_TIMEOUT, exp_to);
          tmo_hit = exp_to;
        end
        @(posedge CLK); #1;
      end
      RX_VLD = 1'b0;
      check("wait_resolved", done || tmo_hit, 1);
      @(negedge CLK);
      check("end_rsp_vld", RSP_VLD, done);
      check("end_rsp_timeout", RSP_TIMEOUT, 0);
      check("end_cmd_rdy", CMD_RDY, tmo_hit);
      check("end_rsp_data", RSP_DATA, exp_rsp);
      @(posedge CLK); #1;
    end
    last_rsp = exp_rsp;
    @(negedge CLK);
    check("back_idle", CMD_RDY, 1);
    check("idle_rsp_vld", RSP_VLD, 0);
    check("rsp_hold", RSP_DATA, last_rsp);
    @(posedge CLK); #1;
  endtask

  // Stray RX strobe while idle must not touch the held response
  task automatic idle_stray();
    RX_VLD  = 1'b1;
    RX_DATA = 8'hFF;
    @(negedge CLK);
    check("stray_idle_rdy", CMD_RDY, 1);
    @(posedge CLK); #1;
    RX_VLD = 1'b0;
    @(negedge CLK);
    check("stray_idle_rsp", RSP_DATA, last_rsp);
    check("stray_idle_vld", RSP_VLD, 0);
    @(posedge CLK); #1;
  endtask

  task automatic set_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] f, input logic [15:0] tmo,
                         input int txm, input bit stray);
    p_type = t; p_addr = ad; p_a = a; p_b = b; p_fun = f;
    p_tmo = tmo; p_txmode = txm; p_stray = stray;
    p_nrx = exp_rsp_len(t);
  endtask

  initial begin
    int rlen, span;
    RST = 1'b0;
    CMD_VLD = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_DATA = '0; CMD_OPB = '0;
    CMD_FUN = '0; TIMEOUT_CYC = '0; TX_RDY = 1'b0; RX_DATA = '0; RX_VLD = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_rdy", CMD_RDY, 1);
    check("rst_tx_vld", TX_VLD, 0);
    check("rst_tx_data", TX_DATA, 0);
    check("rst_rsp_data", RSP_DATA, 0);
    check("rst_rsp_vld", RSP_VLD, 0);
    check("rst_rsp_timeout", RSP_TIMEOUT, 0);
    #2 RST = 1'b1;
    @(posedge CLK); #1;

    // RF write, addr 3, data 5A
    set_cmd(2'b00, 4'h3, 8'h5A, 8'h00, 4'h0, 16'd0, 0, 0);
    run_cmd();

    // RF read, addr 2, response 81
    set_cmd(2'b01, 4'h2, 8'h00, 8'h00, 4'h0, 16'd0, 0, 0);
    p_rx[0] = 8'h81; p_rx_at[0] = 2;
    run_cmd();

    // ALU op with TX_RDY toggling, response 46,00
    set_cmd(2'b10, 4'h0, 8'h12, 8'h34, 4'h1, 16'd0, 1, 0);
    p_rx[0] = 8'h46; p_rx_at[0] = 1;
    p_rx[1] = 8'h00; p_rx_at[1] = 3;
    run_cmd();

    // ALU nop, one byte then silence -> timeout 10 cycles after the byte
    set_cmd(2'b11, 4'h0, 8'h00, 8'h00, 4'h2, 16'd10, 0, 0);
    p_nrx = 1; p_rx[0] = 8'h07; p_rx_at[0] = 2;
    run_cmd();

    // Stray strobes in idle and during send
    idle_stray();
    set_cmd(2'b01, 4'h9, 8'h00, 8'h00, 4'h0, 16'd0, 2, 1);
    p_rx[0] = 8'h3C; p_rx_at[0] = 0;
    run_cmd();

    // Bytes exactly on the terminal-count cycle win over the timeout
    set_cmd(2'b10, 4'h0, 8'hA5, 8'h5A, 4'hF, 16'd4, 0, 0);
    p_rx[0] = 8'h11; p_rx_at[0] = 4;
    p_rx[1] = 8'h22; p_rx_at[1] = 8;
    run_cmd();

    // No response at all -> timeout with empty response
    set_cmd(2'b01, 4'h1, 8'h00, 8'h00, 4'h0, 16'd3, 0, 0);
    p_nrx = 0;
    run_cmd();

    // Reset asserted while the second byte of an ALU frame is on the wire
    CMD_VLD = 1'b1; CMD_TYPE = 2'b10; CMD_DATA = 8'h9C; CMD_OPB = 8'h21; CMD_FUN = 4'h3;
    @(posedge CLK); #1;
    CMD_VLD = 1'b0;
    TX_RDY  = 1'b1;
    @(negedge CLK);
    check("rst_frame_op", TX_DATA, 8'hCC);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst_frame_b2", TX_DATA, 8'h9C);
    #2 RST = 1'b0;
    #1;
    check("midrst_tx_vld", TX_VLD, 0);
    check("midrst_cmd_rdy", CMD_RDY, 1);
    check("midrst_tx_data", TX_DATA, 0);
    check("midrst_rsp_data", RSP_DATA, 0);
    @(posedge CLK); #1;
    TX_RDY = 1'b0;
    @(negedge CLK);
    check("midrst_no_vld", RSP_VLD, 0);
    check("midrst_no_tmo", RSP_TIMEOUT, 0);
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    last_rsp = 16'h0;
    set_cmd(2'b01, 4'h7, 8'h00, 8'h00, 4'h0, 16'd0, 0, 0);
    p_rx[0] = 8'hE4; p_rx_at[0] = 1;
    run_cmd();

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      set_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              ($urandom_range(0, 1) != 0) ? 16'($urandom_range(3, 12)) : 16'd0,
              int'($urandom_range(0, 2)), 1'($urandom));
      rlen = exp_rsp_len(p_type);
      span = (p_tmo != 0) ? int'(p_tmo) : 15;
      p_rx[0] = 8'($urandom);
      p_rx[1] = 8'($urandom);
      p_rx_at[0] = int'($urandom_range(0, span));
      p_rx_at[1] = p_rx_at[0] + int'($urandom_range(1, span));
      if (rlen > 0 && p_tmo != 0 && $urandom_range(0, 2) == 0) begin
        p_nrx = int'($urandom_range(0, rlen - 1));
      end
      run_cmd();
      if ($urandom_range(0, 2) == 0) idle_stray();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_host.md
# uart_cmd_host

Host-side command initiator for the UART register/ALU command protocol. Accepts one command per request, serialises it into a byte frame on a byte-wide UART TX interface, and then collects the response bytes from a byte-wide UART RX interface. It returns the assembled response, or flags a timeout. It is the initiator for the system's command responder and is used in host bridges and as the bench driver for the full transceiver.

## Interface
- DATA_WIDTH, 8, byte width of frames and operands
- RF_ADDR, 4, register-file address width; zero-extended to one byte on the wire
- TIMEOUT_W, 16, width of timeout counter and TIMEOUT_CYC
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-low
- CMD_VLD  in  1  command request valid
- CMD_RDY  out  1  host idle, can accept a command
- CMD_TYPE  in  2  00 RF write, 01 RF read, 10 ALU with operands, 11 ALU no operands
- CMD_ADDR  in  RF_ADDR  register address (write/read)
- CMD_DATA  in  DATA_WIDTH  write data (type 00) or operand A (type 10)
- CMD_OPB  in  DATA_WIDTH  operand B (type 10)
- CMD_FUN  in  4  ALU function code (types 10/11)
- TIMEOUT_CYC  in  TIMEOUT_W  response timeout in CLK cycles; 0 disables the timeout
- TX_DATA  out  DATA_WIDTH  frame byte to UART TX
- TX_VLD  out  1  TX_DATA valid
- TX_RDY  in  1  TX side accepts the byte this cycle
- RX_DATA  in  DATA_WIDTH  received byte
- RX_VLD  in  1  one-cycle strobe qualifying RX_DATA
- RSP_DATA  out  2*DATA_WIDTH  response value
- RSP_VLD  out  1  one-cycle pulse: command complete
- RSP_TIMEOUT  out  1  one-cycle pulse: command aborted by timeout

## Operation
- Frames:
  - 00: AA, addr, data
  - 01: BB, addr
  - 10: CC, A, B, FUN
  - 11: DD, FUN
  - addr and FUN are zero-extended to 8 bits.
- Expected response bytes: 00→0, 01→1, 10/11→2 (LSB first).
- FSM states:
  - IDLE: CMD_RDY=1. On CMD_VLD, latch all CMD_* fields, clear RSP_DATA, go to SEND.
  - SEND: TX_VLD=1, TX_DATA=frame[byte_cnt]. Advance byte_cnt on TX_VLD&&TX_RDY. After the last byte is accepted, go to DONE if 0 response bytes are expected, else to WAIT_RSP.
  - WAIT_RSP: on RX_VLD, store the byte (first→RSP_DATA[7:0], second→RSP_DATA[15:8]) and reload the timeout counter. When all expected bytes are received, go to DONE. If the counter reaches TIMEOUT_CYC (non-zero) with no RX_VLD that cycle, pulse RSP_TIMEOUT and go to IDLE.
  - DONE: pulse RSP_VLD for one cycle, go to IDLE.
- RX_VLD is ignored in IDLE, SEND and DONE; stray bytes are dropped.
- TX_DATA and TX_VLD stay stable until accepted; TX_VLD never drops mid-byte.
- CMD_* inputs are sampled only at acceptance. Later changes have no effect.
- RSP_DATA holds its value until the next command is accepted. On timeout it holds the partial bytes received.

## Timing
- Reset values: CMD_RDY=1, TX_VLD=0, TX_DATA=0, RSP_DATA=0, RSP_VLD=0, RSP_TIMEOUT=0, FSM=IDLE, all counters 0.
- CMD_VLD&&CMD_RDY in cycle N: CMD_RDY=0 and TX_VLD=1 with the opcode byte in cycle N+1.
- With TX_RDY held high, the frame uses one byte per cycle, so a 4-byte frame occupies cycles N+1..N+4.
- Write command: RSP_VLD in the cycle after the last byte is accepted. CMD_RDY=1 the cycle after that.
- Read/ALU command: RSP_VLD in the cycle after the final RX_VLD.
- Timeout counter: starts at 0 on WAIT_RSP entry and increments each cycle. RSP_TIMEOUT fires in the cycle the count equals TIMEOUT_CYC.
- RX_VLD in the terminal-count cycle: the byte wins and no timeout occurs.
- RST asserted mid-frame: immediate return to reset values. The partial frame is abandoned and no RSP pulse is issued.

## Structure
- Package uart_host_pkg holds:
  - opcode constants: RF_WR=AA, RF_RD=BB, ALU_OP=CC, ALU_NOP=DD
  - CMD_TYPE encodings
  - state enum
  - per-type frame length and response length constants
- Sub-module uart_host_timeout is the loadable timeout counter. It has inputs clear, enable and limit, and output expired; limit=0 means it never expires.
- Frame-byte selection is a combinational mux in the top, indexed by byte_cnt.

## Test plan
- RF write, addr 3, data 5A, TX_RDY=1 → TX bytes AA,03,5A on consecutive cycles; RSP_VLD one cycle later with RSP_DATA=0000.
- RF read, addr 2; responder returns 81 → TX bytes BB,02; RSP_VLD with RSP_DATA=0081.
- ALU op, A=12, B=34, FUN=1, TX_RDY toggling 1/0 → TX bytes CC,12,34,01, each held until accepted; RX bytes 46,00 → RSP_DATA=0046.
- ALU nop, FUN=2, TIMEOUT_CYC=10; one RX byte 07, then silence → RSP_TIMEOUT 10 cycles after that byte, no RSP_VLD, RSP_DATA=0007, CMD_RDY=1 next cycle.
- Stray RX_VLD (FF) in IDLE and during SEND → ignored; RSP_DATA is set only from the bytes received in WAIT_RSP.
- RST low during byte 2 of a CC frame → TX_VLD=0 and CMD_RDY=1 immediately. A new read command afterwards completes correctly.
